icache_refill_bridge: RTL and testbench
=======================================

ICACHE_REFILL_BRIDGE -- requirements
Module: icache_refill_bridge

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, the number of 32-bit beats per cache line.
REQ-002 SHALL have parameter ADDR_W, default 32, the request and AXI address width.
REQ-003 SHALL have port clk, input, 1, clock; rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, ICache line-refill request valid.
REQ-005 SHALL have port req_ready, output, 1, bridge able to accept a request.
REQ-006 SHALL have port req_pc, input, ADDR_W, miss address from ICache.
REQ-007 SHALL have port res_valid, output, 1, assembled line valid.
REQ-008 SHALL have port res_ready, input, 1, ICache accepts line.
REQ-009 SHALL have port res_Rdata, output, 32*LINE_BEATS, assembled line; beat i occupies bits [32i+31:32i].
REQ-010 SHALL have AXI read-address ports: araddr (output, ADDR_W), arlen (output, 8), arsize (output, 3), arburst (output, 2), arvalid (output, 1), arready (input, 1).
REQ-011 SHALL have AXI read-data ports: rdata (input, 32), rresp (input, 2), rlast (input, 1), rvalid (input, 1), rready (output, 1).

Function
REQ-012 SHALL implement the states IDLE, ADDR, DATA and RESP.
REQ-013 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL latch req_pc with the low 4 bits cleared, clear the beat counter, and enter ADDR.
REQ-014 SHALL assert arvalid only in ADDR, holding araddr stable until arready, with arlen=LINE_BEATS-1, arsize=3'b010 and arburst=2'b01 (INCR).
REQ-015 SHALL enter DATA on arvalid&&arready; arvalid is first high the cycle after request acceptance.
REQ-016 SHALL drive rready=1 only in DATA; each rvalid&&rready beat SHALL write rdata into line word[counter] and increment the counter.
REQ-017 SHALL leave DATA for RESP on the beat with rlast=1 or on the LINE_BEATS-th beat, whichever comes first.
REQ-018 SHALL, on an early rlast, zero the unwritten words.
REQ-019 SHALL ignore extra beats arriving after the LINE_BEATS-th beat, since rready is already low by then.
REQ-020 SHALL assert res_valid in RESP, the cycle after the final beat, holding res_Rdata stable until res_ready.
REQ-021 SHALL return to IDLE on res_valid&&res_ready, so req_ready is 1 in the following cycle.
REQ-022 SHALL ignore req_valid outside IDLE.
REQ-023 SHALL process one outstanding request at a time.
REQ-024 SHALL have a minimum request-to-res_valid latency of LINE_BEATS+2 cycles when arready and rvalid are held high.

Reset
REQ-025 SHALL, on rst low, asynchronously enter IDLE and set arvalid=0, rready=0, res_valid=0, res_Rdata=0, araddr=0, counter=0.
REQ-026 SHALL drive req_ready=1 from the first cycle after reset release.
REQ-027 SHALL abandon any in-flight request on reset mid-operation; no response is produced for it.

Configuration
REQ-028 SHALL, with macro ICACHE_REFILL_ERR_EN defined, add output res_err (1 bit, reset 0) that is valid with res_valid.
REQ-029 SHALL, with ICACHE_REFILL_ERR_EN defined, set res_err to 1 if any beat had rresp!=2'b00 or rlast arrived before beat LINE_BEATS; res_err is cleared on request acceptance.
REQ-030 SHALL, without ICACHE_REFILL_ERR_EN, omit the res_err port entirely; the data path is otherwise identical.

Structure
REQ-031 SHALL take the state enum and the AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY) from shared package icache_pkg.
REQ-032 SHALL use one sub-module, refill_beat_packer (counter, word write and zero-fill); everything else is implemented in the top FSM.

Verification
REQ-033 SHALL cover a normal refill: req_pc=0x1C00_0024, arready=rvalid=1, rdata=0x11,0x22,0x33,0x44 with rlast on beat 4 -> araddr=0x1C00_0020, arlen=3, res_Rdata=0x00000044_00000033_00000022_00000011, res_valid at cycle 6.
REQ-034 SHALL cover backpressure: arready low 3 cycles, rvalid gapped, res_ready low 2 cycles -> araddr, arvalid and res_Rdata held stable, with no lost or duplicated beat.
REQ-035 SHALL cover early rlast on beat 2 -> words 2-3 are zero; with ICACHE_REFILL_ERR_EN, res_err=1.
REQ-036 SHALL cover rresp=2'b10 on beat 3 -> line assembled; with ICACHE_REFILL_ERR_EN, res_err=1, and the next clean refill has res_err=0.
REQ-037 SHALL cover rst pulsed low mid-DATA -> all outputs at reset values immediately, req_ready=1 after release, and a new request completes correctly.
REQ-038 SHALL cover back-to-back requests with req_valid held high -> second accepted the cycle after the first res handshake, with correct independent data.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared ICache refill types: FSM state encoding and AXI4 read-channel constants.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int unsigned BEAT_W     = 32;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

endpackage

// File: rtl/refill_beat_packer.sv
// Assembles AXI read beats into a cache line: beat counter, word write and
// zero-fill of the words left unwritten when a burst ends early.
module refill_beat_packer
  import icache_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         beat_en,
  input  logic                         beat_last,
  input  logic [BEAT_W-1:0]            beat_data,
  output logic                         last_slot_c,
  output logic [BEAT_W*LINE_BEATS-1:0] line
);

  localparam int unsigned CNT_W = $clog2(LINE_BEATS) + 1;

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [LINE_BEATS-1:0][BEAT_W-1:0] line_q, line_d;

  assign last_slot_c = (cnt_q == CNT_W'(LINE_BEATS - 1));

  // Write the current slot; a last-flagged beat also clears every slot above it.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int unsigned i = 0; i < LINE_BEATS; i++) begin
        if (CNT_W'(i) == cnt_q) begin
          line_d[i] = beat_data;
        end else if (beat_last && (CNT_W'(i) > cnt_q)) begin
          line_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/icache_refill_bridge.sv
// ICache line-refill to AXI4 read-burst bridge, one request in flight.
// Define ICACHE_REFILL_ERR_EN to add the res_err response flag.
module icache_refill_bridge
  import icache_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_pc,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [BEAT_W*LINE_BEATS-1:0] res_Rdata,
`ifdef ICACHE_REFILL_ERR_EN
  output logic                         res_err,
`endif
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [BEAT_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              req_ready_q, req_ready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              res_valid_q, res_valid_d;
  logic              pk_clear_c;
  logic              beat_en_c;
  logic              last_slot_c;
  logic              final_beat_c;

  assign beat_en_c    = rvalid && rready_q;
  assign final_beat_c = beat_en_c && (rlast || last_slot_c);

  refill_beat_packer #(
    .LINE_BEATS (LINE_BEATS)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pk_clear_c),
    .beat_en     (beat_en_c),
    .beat_last   (rlast),
    .beat_data   (rdata),
    .last_slot_c (last_slot_c),
    .line        (res_Rdata)
  );

  // Next state; handshake outputs are registered copies of the next state.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    pk_clear_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = ADDR;
          araddr_d   = {req_pc[ADDR_W-1:4], 4'b0000};
          pk_clear_c = 1'b1;
        end
      end
      ADDR: if (arready) state_d = DATA;
      DATA: if (final_beat_c) state_d = RESP;
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == ADDR);
    rready_d    = (state_d == DATA);
    res_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      req_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign res_valid = res_valid_q;
  assign araddr    = araddr_q;
  assign arlen     = 8'(LINE_BEATS - 1);
  assign arsize    = SIZE_4B;
  assign arburst   = BURST_INCR;

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q, err_d;
  logic unused_c;

  // Sticky per-line error: bad response or a burst shorter than the line.
  always_comb begin
    err_d = err_q;
    if (pk_clear_c) begin
      err_d = 1'b0;
    end else if (beat_en_c && ((rresp != RESP_OKAY) || (rlast && !last_slot_c))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign res_err  = err_q;
  assign unused_c = ^req_pc[3:0];
`else
  logic unused_c;
  assign unused_c = ^{req_pc[3:0], rresp};
`endif

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed self-checking bench for icache_refill_bridge (LINE_BEATS=4, ADDR_W=32).
module tb_icache_refill_bridge;

  localparam int unsigned LB = 4;
  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic [AW-1:0]   req_pc = '0;
  logic            res_ready = 1'b0;
  logic            arready = 1'b0;
  logic [31:0]     rdata = '0;
  logic [1:0]      rresp = '0;
  logic            rlast = 1'b0;
  logic            rvalid = 1'b0;
  logic            req_ready, res_valid, arvalid, rready;
  logic [32*LB-1:0] res_Rdata;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
`ifdef ICACHE_REFILL_ERR_EN
  logic            res_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  icache_refill_bridge #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .res_valid(res_valid), .res_ready(res_ready), .res_Rdata(res_Rdata),
`ifdef ICACHE_REFILL_ERR_EN
    .res_err(res_err),
`endif
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] pc);
    for (int k = 0; k < 50 && !req_ready; k++) tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  // Present one beat and hold it until the bridge takes it.
  task automatic send_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
    rvalid = 1'b1; rdata = d; rresp = r; rlast = l;
    for (int k = 0; k < 50 && !rready; k++) tick();
    n_checks++;
    if (rready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_timeout: rready=%b required 1", rready);
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic wait_res();
    for (int k = 0; k < 50 && !res_valid; k++) tick();
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL res_timeout: res_valid=%b required 1", res_valid);
    end
  endtask

  task automatic finish_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b required 0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b required 0", rready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
    n_checks++; if (res_Rdata !== '0) begin n_fail++; $display("FAIL rst_res_Rdata: got %h required 0", res_Rdata); end
    n_checks++; if (araddr !== '0) begin n_fail++; $display("FAIL rst_araddr: got %h required 0", araddr); end
    rst = 1'b1;
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    n_checks++; if (arlen !== 8'd3) begin n_fail++; $display("FAIL arlen: got %h required 03", arlen); end
    n_checks++; if (arsize !== 3'b010) begin n_fail++; $display("FAIL arsize: got %b required 010", arsize); end
    n_checks++; if (arburst !== 2'b01) begin n_fail++; $display("FAIL arburst: got %b required 01", arburst); end
`ifdef ICACHE_REFILL_ERR_EN
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL rst_res_err: got %b required 0", res_err); end
`endif
  endtask

  task automatic test_normal();
    int c0;
    logic [32*LB-1:0] exp;
    exp = {32'h44, 32'h33, 32'h22, 32'h11};
    arready = 1'b1;
    c0 = cyc;
    issue(32'h1C00_0024);
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL normal_arvalid: got %b required 1", arvalid); end
    n_checks++; if (araddr !== 32'h1C00_0020) begin n_fail++; $display("FAIL normal_araddr: got %h required 1c000020", araddr); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL normal_req_ready_busy: got %b required 0", req_ready); end
    send_beat(32'h11, 2'b00, 1'b0);
    send_beat(32'h22, 2'b00, 1'b0);
    send_beat(32'h33, 2'b00, 1'b0);
    send_beat(32'h44, 2'b00, 1'b1);
    wait_res();
    n_checks++; if (cyc - c0 != 6) begin n_fail++; $display("FAIL normal_latency: got %0d required 6", cyc - c0); end
    n_checks++; if (res_Rdata !== exp) begin n_fail++; $display("FAIL normal_line: got %h required %h", res_Rdata, exp); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL normal_rready_resp: got %b required 0", rready); end
    finish_res();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL normal_req_ready_after: got %b required 1", req_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL normal_res_valid_after: got %b required 0", res_valid); end
  endtask

  task automatic test_backpressure();
    logic [32*LB-1:0] exp;
    exp = {32'hB000_0004, 32'hB000_0003, 32'hB000_0002, 32'hB000_0001};
    arready = 1'b0;
    issue(32'h0000_1238);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_1230) begin
        n_fail++; $display("FAIL bp_ar_hold%0d: got arvalid=%b araddr=%h required 1/00001230", i, arvalid, araddr);
      end
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b0;
      repeat (i % 2 + 1) tick();
      n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_gap%0d: got %b required 1", i, rready); end
      send_beat(32'hB000_0001 + 32'(i), 2'b00, (i == 3));
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
    wait_res();
    n_checks++; if (res_Rdata !== exp) begin n_fail++; $display("FAIL bp_line: got %h required %h", res_Rdata, exp); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_Rdata !== exp || rready !== 1'b0) begin
        n_fail++; $display("FAIL bp_res_hold%0d: got valid=%b rready=%b line=%h required 1/0/%h", i, res_valid, rready, res_Rdata, exp);
      end
    end
    rvalid = 1'b0; rlast = 1'b0;
    finish_res();
    arready = 1'b1;
  endtask

  task automatic test_early_rlast();
    logic [32*LB-1:0] exp;
    exp = {32'h0, 32'h0, 32'hC000_0002, 32'hC000_0001};
    issue(32'h0000_0040);
    send_beat(32'hC000_0001, 2'b00, 1'b0);
    send_beat(32'hC000_0002, 2'b00, 1'b1);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL early_res_valid: got %b required 1", res_valid); end
    n_checks++; if (res_Rdata !== exp) begin n_fail++; $display("FAIL early_line: got %h required %h", res_Rdata, exp); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL early_rready: got %b required 0", rready); end
`ifdef ICACHE_REFILL_ERR_EN
    n_checks++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL early_res_err: got %b required 1", res_err); end
`endif
    finish_res();
  endtask

  task automatic test_rresp_err();
    logic [32*LB-1:0] exp;
    exp = {32'hD000_0004, 32'hD000_0003, 32'hD000_0002, 32'hD000_0001};
    issue(32'h0000_0100);
    send_beat(32'hD000_0001, 2'b00, 1'b0);
    send_beat(32'hD000_0002, 2'b00, 1'b0);
    send_beat(32'hD000_0003, 2'b10, 1'b0);
    send_beat(32'hD000_0004, 2'b00, 1'b1);
    wait_res();
    n_checks++; if (res_Rdata !== exp) begin n_fail++; $display("FAIL rresp_line: got %h required %h", res_Rdata, exp); end
`ifdef ICACHE_REFILL_ERR_EN
    n_checks++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL rresp_res_err: got %b required 1", res_err); end
`endif
    finish_res();
  endtask

  task automatic test_back_to_back();
    logic [32*LB-1:0] exp1, exp2;
    exp1 = {32'hE000_0004, 32'hE000_0003, 32'hE000_0002, 32'hE000_0001};
    exp2 = {32'hF000_0004, 32'hF000_0003, 32'hF000_0002, 32'hF000_0001};
    req_valid = 1'b1;
    req_pc    = 32'h0000_041C;
    tick();
    req_pc = 32'h0000_0528;
    n_checks++; if (araddr !== 32'h0000_0410) begin n_fail++; $display("FAIL b2b_araddr1: got %h required 00000410", araddr); end
    for (int i = 0; i < 4; i++) send_beat(32'hE000_0001 + 32'(i), 2'b00, (i == 3));
    wait_res();
    n_checks++; if (res_Rdata !== exp1) begin n_fail++; $display("FAIL b2b_line1: got %h required %h", res_Rdata, exp1); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b required 0", req_ready); end
`ifdef ICACHE_REFILL_ERR_EN
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL b2b_res_err_clean: got %b required 0", res_err); end
`endif
    finish_res();
    n_checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got req_ready=%b res_valid=%b required 1/0", req_ready, res_valid);
    end
    tick();
    req_valid = 1'b0;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0520) begin
      n_fail++; $display("FAIL b2b_second_ar: got arvalid=%b araddr=%h required 1/00000520", arvalid, araddr);
    end
    for (int i = 0; i < 4; i++) send_beat(32'hF000_0001 + 32'(i), 2'b00, (i == 3));
    wait_res();
    n_checks++; if (res_Rdata !== exp2) begin n_fail++; $display("FAIL b2b_line2: got %h required %h", res_Rdata, exp2); end
    finish_res();
  endtask

  task automatic test_reset_mid();
    logic [32*LB-1:0] exp;
    exp = {32'h5A00_0004, 32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001};
    issue(32'h0000_0200);
    send_beat(32'h7777_0001, 2'b10, 1'b0);
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_data: got rready=%b required 1", rready); end
    rst = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl: got arvalid=%b rready=%b res_valid=%b required 0/0/0", arvalid, rready, res_valid);
    end
    n_checks++; if (res_Rdata !== '0 || araddr !== '0) begin
      n_fail++; $display("FAIL rmid_data: got line=%h araddr=%h required 0/0", res_Rdata, araddr);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_release: got req_ready=%b res_valid=%b required 1/0", req_ready, res_valid);
    end
    issue(32'h0000_0300);
    n_checks++; if (araddr !== 32'h0000_0300) begin n_fail++; $display("FAIL rmid_araddr: got %h required 00000300", araddr); end
    for (int i = 0; i < 4; i++) send_beat(32'h5A00_0001 + 32'(i), 2'b00, (i == 3));
    wait_res();
    n_checks++; if (res_Rdata !== exp) begin n_fail++; $display("FAIL rmid_line: got %h required %h", res_Rdata, exp); end
`ifdef ICACHE_REFILL_ERR_EN
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL rmid_res_err: got %b required 0", res_err); end
`endif
    finish_res();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_early_rlast();
    test_rresp_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
